pending_encoder8_3: RTL

Sequential 8-to-3 encoder, the inverse of the 3-to-8 decoder. It latches an 8-bit one-hot/multi-hot request word into a pending register and emits one 3-bit index per accepted handshake until no requests remain. It sits between request-generating logic (decoder outputs, status flags) and downstream consumers such as mux select lines or adder operand steering.

---
 rtl/pending_encoder8_3.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pending_encoder8_3.sv
// Sequential 8-to-3 encoder: requests accumulate in a pending register and are
// handed out one index per accepted handshake. Define ENCODER_ROUND_ROBIN_EN for
// round-robin selection; the default build uses fixed lowest-index priority.
module pending_encoder8_3 (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_req,
   input  logic       i_load,
   input  logic       i_ready,
   output logic       o_valid,
   output logic [2:0] o_idx,
   output logic [3:0] o_count,
   output logic       o_dup
);

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'd0, v[i]};
      end
      return c;
   endfunction

`ifdef ENCODER_ROUND_ROBIN_EN
   // Search starts just above the last served index and wraps 7 -> 0.
   function automatic logic [2:0] rr_select(input logic [7:0] v, input logic [2:0] last);
      logic [2:0] sel;
      logic [2:0] cand;
      logic       found;
      sel   = 3'd0;
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cand = last + 3'(k);
         if (!found && v[cand]) begin
            sel   = cand;
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return sel;
   endfunction
`else
   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] sel;
      sel = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) begin
            sel = 3'(i);
         end else begin
            sel = sel;
         end
      end
      return sel;
   endfunction
`endif

   logic [7:0] pending_q;
   logic [7:0] pending_d;
   logic [3:0] count_q;
   logic [3:0] count_d;
   logic       dup_q;
   logic       dup_d;
   logic [2:0] sel_idx;
   logic       acc;
   logic [7:0] acc_mask;
   logic [7:0] load_mask;
`ifdef ENCODER_ROUND_ROBIN_EN
   logic [2:0] last_q;
   logic [2:0] last_d;
`endif

   // Selection, accept handshake and next-state computation.
   always_comb begin
`ifdef ENCODER_ROUND_ROBIN_EN
      sel_idx = rr_select(pending_q, last_q);
`else
      sel_idx = lowest_set(pending_q);
`endif
      acc       = (|pending_q) & i_ready;
      acc_mask  = 8'd0;
      load_mask = 8'd0;
      if (acc) begin
         acc_mask = 8'd1 << sel_idx;
      end else begin
         acc_mask = 8'd0;
      end
      if (i_load) begin
         load_mask = i_req;
      end else begin
         load_mask = 8'd0;
      end
      // Load is ORed in after clearing, so a bit loaded while being accepted survives.
      pending_d = (pending_q & ~acc_mask) | load_mask;
      dup_d     = |(load_mask & pending_q & ~acc_mask);
      count_d   = popcount8(pending_d);
`ifdef ENCODER_ROUND_ROBIN_EN
      if (acc) begin
         last_d = sel_idx;
      end else begin
         last_d = last_q;
      end
`endif
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= 8'd0;
         count_q   <= 4'd0;
         dup_q     <= 1'b0;
`ifdef ENCODER_ROUND_ROBIN_EN
         last_q    <= 3'd7;
`endif
      end else begin
         pending_q <= pending_d;
         count_q   <= count_d;
         dup_q     <= dup_d;
`ifdef ENCODER_ROUND_ROBIN_EN
         last_q    <= last_d;
`endif
      end
   end

   assign o_valid = |pending_q;
   assign o_idx   = sel_idx;
   assign o_count = count_q;
   assign o_dup   = dup_q;

endmodule
